// File: rtl/core_instr_prefetch.sv
// core_instr_prefetch
//   Instruction-fetch front end. Issues word-aligned fetch requests on a
//   req/gnt/rvalid handshake, tracks in-flight transactions, buffers returned
//   words with their PC in a small FIFO and hands them to decode over a
//   valid/ready port. A redirect flushes the buffer and marks every in-flight
//   response (including a still-ungranted request) for discard.
//
// Ports
//   clk_i, reset_i          : clock, synchronous active-high reset
//   instr_req_o/addr_o      : fetch request and word-aligned address
//   instr_gnt_i             : request accepted this cycle
//   instr_rvalid_i/rdata_i  : in-order response
//   redirect_i/addr_i       : one-cycle flush-and-restart pulse, new PC
//   fetch_valid_o/instr_o/pc_o, fetch_ready_i : decode port (FIFO head)
//   fetch_busy_o            : request pending or any response outstanding
module core_instr_prefetch #(
  parameter logic [31:0] BOOT_ADDR       = 32'h3000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  input  logic        fetch_ready_i,
  output logic        fetch_busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  // Holds MAX_OUTSTANDING + 1 so the discard total (in-flight plus a held
  // request) always fits.
  localparam int OW = $clog2(MAX_OUTSTANDING + 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic          run;         // low for the first cycle after reset
  logic          pending;     // request was high last cycle and not granted
  logic          redir_hold;  // redirect arrived while a request was held
  logic [31:0]   redir_addr;
  logic [31:0]   next_addr;
  logic [31:0]   resp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [OW-1:0] out_nxt;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   new_pc;
  logic          credit_ok, req, gnt, hold, rsp, push, pop;

  assign new_pc = redirect_addr_i & 32'hFFFF_FFFC;

  // Credits come from registered state only, so there is no gnt->req path.
  assign credit_ok = (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                     (32'(outstanding) + 32'(count) < 32'(FIFO_DEPTH));
  assign req  = run & (pending | credit_ok);
  assign gnt  = req & instr_gnt_i;
  assign hold = req & ~instr_gnt_i;

  // Responses with nothing outstanding belong to pre-reset traffic; ignore.
  assign rsp     = instr_rvalid_i & (outstanding != '0);
  assign out_nxt = outstanding + OW'(gnt) - OW'(rsp);

  // Redirect wins over push and pop in the same cycle.
  assign push = rsp & ~redirect_i & (discard == '0);
  assign pop  = fetch_valid_o & fetch_ready_i & ~redirect_i;

  assign instr_req_o   = req;
  assign instr_addr_o  = next_addr;
  assign fetch_valid_o = (count != '0);
  assign fetch_pc_o    = mem[rd_ptr].pc;
  assign fetch_instr_o = mem[rd_ptr].instr;
  assign fetch_busy_o  = req | (outstanding != '0);

  // Request/response tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run         <= 1'b0;
      pending     <= 1'b0;
      redir_hold  <= 1'b0;
      redir_addr  <= BOOT_ADDR;
      next_addr   <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run         <= 1'b1;
      pending     <= hold;
      outstanding <= out_nxt;
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the old
        // stream, including a request that is visible but not yet granted.
        discard <= out_nxt + OW'(hold);
        resp_pc <= new_pc;
        if (hold) begin
          // The held request must keep its address; switch after its grant.
          redir_hold <= 1'b1;
          redir_addr <= new_pc;
        end else begin
          redir_hold <= 1'b0;
          next_addr  <= new_pc;
        end
      end else begin
        if (gnt) begin
          next_addr  <= redir_hold ? redir_addr : next_addr + 32'd4;
          redir_hold <= 1'b0;
        end
        if (rsp) begin
          if (discard != '0) discard <= discard - OW'(1);
          else               resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  // Instruction buffer pointers.
  always_ff @(posedge clk_i) begin
    if (reset_i || redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      // Credits guarantee a free slot for every kept response.
      if (push) assert (count < CW'(FIFO_DEPTH));
    end
  end

  // Buffer storage, no reset needed: contents are only read when count != 0.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {resp_pc, instr_rdata_i};
  end

endmodule

// File: doc/core_instr_prefetch.md
# core_instr_prefetch

Instruction-fetch front end sitting between the core's fetch/decode stage and the core instruction interface of `core_instruction_top`.
- Generates word-aligned fetch requests on the `instr_req`/`instr_gnt`/`instr_rvalid` handshake.
- Tracks outstanding transactions and buffers returned words with their PC in a small FIFO.
- Presents instructions to decode over a valid/ready port.
- Handles branch/jump redirects by flushing buffered and in-flight words.

## Interface
- `BOOT_ADDR`, default `32'h3000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, default 4: instruction buffer entries, power of two, at least 2.
- `MAX_OUTSTANDING`, default 2: granted-but-not-returned request limit, at least 1.
- `clk_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `instr_req_o` out 1: fetch request.
- `instr_addr_o` out 32: fetch address; bits [1:0] are always 0.
- `instr_gnt_i` in 1: request accepted in this cycle.
- `instr_rvalid_i` in 1: response data valid; responses return in order.
- `instr_rdata_i` in 32: response instruction word.
- `redirect_i` in 1: one-cycle pulse requesting a flush and restart.
- `redirect_addr_i` in 32: new fetch PC; bits [1:0] are ignored.
- `fetch_valid_o` out 1: FIFO head is valid.
- `fetch_instr_o` out 32: head instruction.
- `fetch_pc_o` out 32: head PC.
- `fetch_ready_i` in 1: decode consumes the head when it is valid and ready is high.
- `fetch_busy_o` out 1: high while any request is outstanding or `instr_req_o` is high.

## Operation
- State:
  - `next_addr`: address of the next request to issue.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: count of granted requests not yet returned.
  - `discard`: count of in-flight responses to drop.
  - `fifo_count`.
- Issue rule:
  - `instr_req_o` = (`outstanding` < `MAX_OUTSTANDING`) and (`outstanding` + `fifo_count` < `FIFO_DEPTH`), or an ungranted request is already pending.
  - The rule uses registered state only; there is no combinational path from `instr_gnt_i` to `instr_req_o`.
- Hold rule: once `instr_req_o` is high, it and `instr_addr_o` stay stable until `instr_gnt_i` arrives. A redirect does not drop or change a pending request.
- On grant: `next_addr` += 4 (wraps modulo 2^32) and `outstanding` += 1.
- On response: `outstanding` -= 1.
  - If `discard` > 0: decrement `discard` and drop the word.
  - Otherwise: push {`resp_pc`, `instr_rdata_i`} into the FIFO and advance `resp_pc` by 4.
- A grant and a response in the same cycle leave `outstanding` unchanged.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- On redirect:
  - FIFO is flushed to empty.
  - `discard` = all in-flight responses, i.e. `outstanding` after this cycle's grant and response, plus 1 if a request is pending ungranted (it is discarded when it returns).
  - `resp_pc` = `{redirect_addr_i[31:2], 2'b00}`.
  - `next_addr` = the same value, applied after any pending old request is granted.
- Redirect has priority over a same-cycle pop and a same-cycle push. The response word arriving in the redirect cycle is dropped and counted against the old stream.
- Redirect while another redirect's discards are in progress: `discard` is recomputed from the current in-flight total, and the newest address wins.
- Pop and push in the same cycle leave `fifo_count` unchanged.
- Reset, which also applies mid-transaction:
  - `instr_req_o`=0, `instr_addr_o`=`BOOT_ADDR`, `fetch_valid_o`=0, `fetch_busy_o`=0.
  - All counters are 0; `resp_pc` = `BOOT_ADDR`.
  - Responses to requests issued before reset are not tracked. The fabric is reset together with this block.

## Timing
- `instr_req_o` first rises in the first cycle after `reset_i` is sampled low.
- Zero-wait fabric (`gnt` in the request cycle, `rvalid` one cycle later): one new request per cycle, sustained while credits allow.
- Response to FIFO head: `rvalid` in cycle N gives `fetch_valid_o`=1 in cycle N+1.
- Redirect in cycle N:
  - `fetch_valid_o`=0 in cycle N+1.
  - The new-address request is visible in cycle N+1 if no old request is pending.
- The FIFO is registered; head outputs come from storage only.

## Test plan
- **Boot stream.** After reset, always grant, `rvalid` one cycle later, with rdata 0x00000013, 0x00100093, 0x00200113.
  - Requests go to 0x3000_0000, 0x3000_0004, 0x3000_0008.
  - Decode sees the same words with matching PCs, in order.
- **Backpressure.** Hold `fetch_ready_i`=0 with default parameters.
  - Exactly 4 grants occur, then `instr_req_o` stays 0.
  - Release ready: the 4 words pop in order and requests resume at 0x3000_0010.
- **Grant stall.** Hold `instr_gnt_i`=0 for 3 cycles.
  - `instr_req_o` and `instr_addr_o`=0x3000_0000 stay stable for all 3 cycles, then are accepted.
- **Redirect with in-flight work.** Assert `redirect_i` with address 0x2000_00B2 while 2 requests are outstanding and the FIFO holds 1 entry.
  - FIFO empties; the 2 old responses are dropped.
  - Next request goes to 0x2000_00B0, and decode sees PC 0x2000_00B0.
- **Redirect while a request is pending.** Assert `redirect_i` to 0x2000_0000 while `req` is high and `gnt` is low.
  - The old address is held until granted and its response is dropped.
  - The following request goes to 0x2000_0000.
- **Mid-stream reset.** Pulse `reset_i` for one cycle during traffic.
  - Next cycle: all outputs are at reset values and `instr_addr_o`=0x3000_0000.
  - The following cycle: `instr_req_o`=1.
